// File: rtl/tdc_pkg.sv
// Shared types for the TDC coarse-stamp path: lock FSM states, lock threshold,
// stamp record layout and the divider phase decode.
package tdc_pkg;

  typedef enum logic [0:0] {
    ST_ACQ  = 1'b0,
    ST_LOCK = 1'b1
  } tdc_state_e;

  localparam int LOCK_STEPS = 4;

  localparam int TDC_COARSE_W = 16;
  localparam int TDC_FINE_W   = 8;

  typedef struct packed {
    logic [TDC_COARSE_W-1:0] coarse;
    logic [TDC_FINE_W-1:0]   fine;
  } stamp_t;

  // Divider raw output runs 11,10,01,00; inverting it gives a 0..3 up-count.
  function automatic logic [1:0] decode_phase(input logic two, input logic one);
    return ~{two, one};
  endfunction

endpackage

// File: rtl/tdc_stamp_fifo.sv
// First-word-fall-through stamp buffer; pointers carry a wrap bit so that
// full and empty are distinguishable without a separate count.
module tdc_stamp_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Head reads as zero when empty so the output is defined straight out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tdc_coarse_stamp.sv
// Coarse-time stamper: decodes the toggle-divider phase, tracks its lock,
// extends it into a free-running coarse count and buffers {coarse, fine} hits.
//   state   | meaning
//   ST_ACQ  | counting consecutive good divider steps; hits discarded
//   ST_LOCK | divider stepping cleanly; hits are stamped and buffered
module tdc_coarse_stamp
  import tdc_pkg::*;
#(
  parameter int COARSE_W = 16,
  parameter int FINE_W   = 8,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       div_one,
  input  logic                       div_two,
  input  logic                       hit,
  input  logic [FINE_W-1:0]          fine_code,
  output logic                       out_valid,
  output logic [COARSE_W+FINE_W-1:0] out_data,
  input  logic                       out_ready,
  output logic                       locked,
  output logic                       phase_err,
  output logic [7:0]                 drop_cnt
);
  localparam int UW = COARSE_W - 2;
  localparam logic [UW-1:0] UPPER_ONE = UW'(1);
  localparam logic [1:0]    LAST_STEP = 2'(LOCK_STEPS - 1);

  logic          one_r, two_r;
  logic          src_ok, prev_ok;
  logic [1:0]    phase, phase_prev;
  logic [UW-1:0] upper;
  logic          step_valid, good_step, wrap;

  tdc_state_e    state_q, state_d;
  logic [1:0]    good_cnt_q, good_cnt_d;
  logic          phase_err_q, phase_err_d;

  logic          wr_req, pop, push, drop, fifo_empty, fifo_full;

  assign phase = decode_phase(two_r, one_r);
  // Steps are judged only once phase_prev holds a sampled divider value, not
  // the reset value.
  assign step_valid = src_ok && prev_ok;
  assign good_step  = step_valid && (phase == phase_prev + 2'd1);
  assign wrap       = step_valid && (phase_prev == 2'd3) && (phase == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      one_r      <= 1'b0;
      two_r      <= 1'b0;
      src_ok     <= 1'b0;
      prev_ok    <= 1'b0;
      phase_prev <= 2'd3;
      upper      <= '0;
    end else begin
      one_r      <= div_one;
      two_r      <= div_two;
      src_ok     <= 1'b1;
      prev_ok    <= src_ok;
      phase_prev <= phase;
      if (wrap) upper <= upper + UPPER_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACQ;
      good_cnt_q  <= 2'd0;
      phase_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      phase_err_q <= phase_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    phase_err_d = phase_err_q;
    case (state_q)
      ST_ACQ: begin
        if (!good_step) begin
          good_cnt_d = 2'd0;
        end else if (good_cnt_q == LAST_STEP) begin
          good_cnt_d = 2'd0;
          state_d    = ST_LOCK;
        end else begin
          good_cnt_d = good_cnt_q + 2'd1;
        end
      end
      ST_LOCK: begin
        if (!good_step) begin
          state_d     = ST_ACQ;
          good_cnt_d  = 2'd0;
          phase_err_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_ACQ;
        good_cnt_d = 2'd0;
      end
    endcase
  end

  assign locked    = (state_q == ST_LOCK);
  assign phase_err = phase_err_q;

  assign wr_req    = hit && locked;
  assign pop       = out_valid && out_ready;
  assign push      = wr_req && (!fifo_full || pop);
  assign drop      = wr_req && !push;
  assign out_valid = !fifo_empty;

  tdc_stamp_fifo #(
    .W     (COARSE_W + FINE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({upper, phase, fine_code}),
    .pop   (pop),
    .empty (fifo_empty),
    .full  (fifo_full),
    .rdata (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tdc_coarse_stamp.sv
// Bench for tdc_coarse_stamp: stamp-value table, directed corner sequences and
// a randomized run, all against a queue-based behavioural model.
module tb_tdc_coarse_stamp;
  import tdc_pkg::*;

  localparam int COARSE_W = 16;
  localparam int FINE_W   = 8;
  localparam int DEPTH    = 8;
  localparam int DW       = COARSE_W + FINE_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          div_one, div_two, hit, out_ready;
  logic [7:0]    fine_code;
  logic          out_valid, locked, phase_err;
  logic [DW-1:0] out_data;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  tdc_coarse_stamp #(.COARSE_W(COARSE_W), .FINE_W(FINE_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_one   (div_one),
    .div_two   (div_two),
    .hit       (hit),
    .fine_code (fine_code),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .locked    (locked),
    .phase_err (phase_err),
    .drop_cnt  (drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: sampled phase history, run of good steps, queue buffer.
  int            m_n, m_cur, m_prev, m_run, m_upper, m_drops;
  bit            m_locked, m_err;
  logic [DW-1:0] m_q[$];

  int div_cnt = 0;
  bit one_force = 0;

  typedef struct {
    logic [7:0]    fine;
    int            upper;
    int            phase;
    logic [DW-1:0] exp_data;
  } stamp_vec_t;

  stamp_vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_div();
    int raw;
    raw = 3 - (div_cnt % 4);
    div_two = raw[1];
    div_one = raw[0] | one_force;
  endtask

  task automatic model_reset();
    m_n = 0; m_cur = 3; m_prev = 3; m_run = 0; m_upper = 0; m_drops = 0;
    m_locked = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("out_data", 32'(out_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check("locked", 32'(locked), 32'(m_locked));
    check("phase_err", 32'(phase_err), 32'(m_err));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  task automatic tick();
    bit d1, d2, h, r, valid, good, pop;
    logic [7:0] f;
    int pre_size;
    stamp_t st;
    d1 = div_one; d2 = div_two; h = hit; r = out_ready; f = fine_code;
    @(posedge clk);
    #1;
    valid = (m_n >= 2);
    good = valid && (((m_prev + 1) % 4) == m_cur);
    pre_size = m_q.size();
    pop = (pre_size > 0) && r;
    if (pop) void'(m_q.pop_front());
    if (h && m_locked) begin
      if (pre_size < DEPTH || pop) begin
        st.coarse = 16'(m_upper * 4 + m_cur);
        st.fine = f;
        m_q.push_back(st);
      end else if (m_drops < 255) begin
        m_drops++;
      end
    end
    if (valid && m_prev == 3 && m_cur == 0) m_upper = (m_upper + 1) % 16384;
    if (m_locked) begin
      if (!good) begin
        m_locked = 0; m_err = 1; m_run = 0;
      end
    end else begin
      m_run = good ? m_run + 1 : 0;
      if (m_run == LOCK_STEPS) begin
        m_locked = 1; m_run = 0;
      end
    end
    m_prev = m_cur;
    m_cur = 3 - (int'(d2) * 2 + int'(d1));
    m_n++;
    compare_all();
    div_cnt++;
    drive_div();
  endtask

  initial begin
    logic [13:0] u0;
    int guard, force_left;
    logic [7:0] exp_fine[8];

    vecs[0] = '{fine: 8'h5A, upper: 3, phase: 2, exp_data: 24'h000E5A};
    vecs[1] = '{fine: 8'h81, upper: 4, phase: 1, exp_data: 24'h001181};
    vecs[2] = '{fine: 8'hFF, upper: 5, phase: 3, exp_data: 24'h0017FF};
    vecs[3] = '{fine: 8'h00, upper: 7, phase: 0, exp_data: 24'h001C00};

    hit = 0; out_ready = 0; fine_code = 0;
    div_cnt = 0; drive_div();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_phase_err", 32'(phase_err), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    model_reset();
    div_cnt = 0; drive_div();
    rst_n = 1;

    // Lock from reset; hits offered during acquisition must vanish.
    hit = 1; fine_code = 8'h33;
    repeat (5) tick();
    check("lock_early", 32'(locked), 0);
    tick();
    check("lock_at_6", 32'(locked), 1);
    hit = 0;
    check("acq_hit_valid", 32'(out_valid), 0);
    check("acq_hit_drop", 32'(drop_cnt), 0);

    // Stamp table: hit at a chosen {upper, phase}, expect the literal stamp.
    for (int i = 0; i < 4; i++) begin
      guard = 0;
      while (!(m_upper == vecs[i].upper && m_cur == vecs[i].phase) && guard < 64) begin
        tick();
        guard++;
      end
      check("stamp_wait_timeout", 32'(guard < 64), 1);
      hit = 1; fine_code = vecs[i].fine;
      tick();
      hit = 0;
      check("stamp_valid", 32'(out_valid), 1);
      check("stamp_data", 32'(out_data), 32'(vecs[i].exp_data));
      out_ready = 1;
      tick();
      out_ready = 0;
    end

    u0 = dut.upper;
    repeat (8) tick();
    check("upper_rate", 32'(14'(dut.upper - u0)), 2);

    // Phase fault: hold div_one high for two extra cycles.
    one_force = 1; drive_div();
    repeat (2) tick();
    one_force = 0; drive_div();
    repeat (2) tick();
    check("fault_unlocked", 32'(locked), 0);
    check("fault_err", 32'(phase_err), 1);
    repeat (4) tick();
    check("relock", 32'(locked), 1);
    check("err_sticky", 32'(phase_err), 1);

    // Overflow: 10 hits into 8 entries, then push-while-pop on full.
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      hit = 1; fine_code = 8'(i);
      tick();
    end
    check("ovf_drop2", 32'(drop_cnt), 2);
    hit = 1; fine_code = 8'hAA; out_ready = 1;
    tick();
    hit = 0;
    check("ovf_pwp_drop", 32'(drop_cnt), 2);
    for (int i = 0; i < 7; i++) exp_fine[i] = 8'(i + 1);
    exp_fine[7] = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", 32'(out_data[7:0]), 32'(exp_fine[i]));
      tick();
    end
    check("ovf_drained", 32'(out_valid), 0);

    // Async reset with five entries buffered.
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      hit = 1; fine_code = 8'(8'h40 + i);
      tick();
    end
    hit = 0;
    #2;
    rst_n = 0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_data", 32'(out_data), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_err", 32'(phase_err), 0);
    check("arst_drop", 32'(drop_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;
    check("arst_upper", 32'(dut.upper), 0);
    guard = 0;
    while (!m_locked && guard < 20) begin
      tick();
      guard++;
    end
    check("arst_relock_timeout", 32'(guard < 20), 1);

    // Randomized traffic with occasional divider faults.
    force_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (force_left == 0 && $urandom_range(0, 99) == 0) force_left = $urandom_range(1, 2);
      one_force = (force_left > 0);
      if (force_left > 0) force_left--;
      drive_div();
      hit = ($urandom_range(0, 2) == 0);
      fine_code = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    one_force = 0; drive_div(); hit = 0;

    // Drop counter saturation.
    guard = 0;
    while (!m_locked && guard < 20) begin
      tick();
      guard++;
    end
    check("sat_lock_timeout", 32'(guard < 20), 1);
    out_ready = 0;
    for (int i = 0; i < 268; i++) begin
      hit = 1; fine_code = 8'($urandom);
      tick();
    end
    hit = 0;
    check("drop_saturated", 32'(drop_cnt), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdc_coarse_stamp.md
# tdc_coarse_stamp

Coarse-time stamping stage that sits directly downstream of the two-stage toggle divider in the TDC. It samples the divider's `one` (clk/2) and `two` (clk/4) outputs in the `clk` domain and checks that they advance correctly. It extends them into a free-running coarse count. On each hit from the fine delay-line encoder, it pushes a `{coarse, fine}` timestamp into a small first-word-fall-through buffer with a valid/ready readout.

## Interface
- `COARSE_W`, 16 — coarse timestamp width; the low 2 bits are the divider phase; ≥ 4.
- `FINE_W`, 8 — width of the binary fine bin from the encoder.
- `DEPTH`, 8 — buffer depth in entries; power of two, ≥ 2.
- `clk`  in  1  system clock; the same clock that drives the divider.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `div_one`  in  1  divider clk/2 output.
- `div_two`  in  1  divider clk/4 output.
- `hit`  in  1  single-cycle hit strobe from the fine encoder, already in the `clk` domain.
- `fine_code`  in  FINE_W  fine bin; valid only when `hit`=1.
- `out_valid`  out  1  buffer head is valid.
- `out_data`  out  COARSE_W+FINE_W  `{coarse, fine}` at the buffer head.
- `out_ready`  in  1  consumer accepts the head.
- `locked`  out  1  phase tracker is in LOCK.
- `phase_err`  out  1  sticky; set on any phase misstep while in LOCK.
- `drop_cnt`  out  8  saturating count of hits lost because the buffer was full.

## Operation
- **Phase decode.**
  - `div_one` and `div_two` are each registered once on `clk`.
  - `phase = ~{two_r, one_r}`.
  - The divider's raw sequence is 11, 10, 01, 00, so `phase` counts 0, 1, 2, 3, 0, ….
  - `phase_prev` holds the previous cycle's `phase`.
  - A step is good when `phase == phase_prev + 1` (mod 4).
- **Coarse count.**
  - `upper` is COARSE_W-2 bits. It increments when `phase_prev==3 && phase==0`, wraps modulo 2^(COARSE_W-2), and is cleared only by reset.
  - `coarse = {upper, phase}`.
- **FSM states.** ACQ (reset state) and LOCK.
  - ACQ: a 2-bit good-step counter counts consecutive good steps and clears on any bad step. The fourth consecutive good step moves to LOCK.
  - LOCK: any bad step returns to ACQ, sets `phase_err`, and clears the good-step counter.
  - `locked` = (state == LOCK).
- **Stamping.**
  - With `hit`=1 in LOCK, `{coarse, fine_code}` is written, using `coarse` as it stands in the hit cycle.
  - With `hit`=1 in ACQ, the hit is discarded silently and not counted in `drop_cnt`.
- **Buffer.**
  - The write is accepted when the buffer is not full, or when it is full and a pop occurs in the same cycle (push-while-pop).
  - Otherwise the hit is dropped and `drop_cnt` increments, saturating at 255.
  - A pop occurs when `out_valid && out_ready`.
  - Empty with a simultaneous hit: no pop that cycle; the entry appears on the next cycle.
- **Reset values:** `out_valid`=0, `out_data`=0, `locked`=0, `phase_err`=0, `drop_cnt`=0, `upper`=0, state=ACQ, buffer empty.
- **Reset mid-operation:** asynchronous clear of all of the above; buffered entries are lost.

## Timing
- Divider pins → `phase`: 1 register stage.
- The reset state of `one_r`/`two_r` is 0, so the first decoded `phase` is 3. The first comparison is not a good step; ACQ absorbs it.
- Minimum time to LOCK after the divider runs cleanly: 6 cycles.
- Hit sampled on edge t (LOCK, buffer not full) → entry written on edge t → `out_valid`=1 after edge t, with `out_data` equal to the stamp.
- With `out_ready` held at 1, sustained throughput is 1 entry per cycle.
- `out_data` is stable while `out_valid && !out_ready`.
- `phase_err` asserts on the edge following the bad step.
- `locked` drops on that same edge.

## Structure
- Shared `tdc_pkg`:
  - the FSM state enum (ACQ, LOCK);
  - the `LOCK_STEPS`=4 constant;
  - the stamp struct `{coarse, fine}` sized from COARSE_W and FINE_W.
- Sub-module `tdc_stamp_fifo`: synchronous FWFT FIFO of DEPTH × (COARSE_W+FINE_W).
  - Pointers carry an extra wrap bit for full/empty.
  - Push-while-pop is legal when full.
- The top level holds the phase decode, the FSM, `upper`, and drop accounting.

## Test plan
- **Reset and lock.** Release reset with a correct divider model running → `locked`=1 six cycles later; `phase_err`=0; `upper` increments once every 4 cycles.
- **Stamp value.** `hit` with `fine_code`=0x5A at `upper`=3, `phase`=2 (COARSE_W=16) → `out_valid` next cycle; `out_data` = {16'h000E, 8'h5A}.
- **Phase fault.** In LOCK, force `div_one` high for 2 extra cycles → `phase_err`=1 and sticky; `locked`=0; relock after 4 good steps; `phase_err` stays 1.
- **Overflow.** `out_ready`=0, 10 hits with DEPTH=8 → 8 entries in order, `drop_cnt`=2. Hit on the full buffer with `out_ready`=1 → accepted, `drop_cnt` unchanged.
- **Hit in ACQ.** Hit during acquisition → no entry, `drop_cnt`=0.
- **Async reset.** Assert `rst_n` low with 5 entries buffered → `out_valid`=0 immediately; after release the buffer is empty and `upper`=0.
